// File: rtl/npu_dot_sched.sv
// npu_dot_sched
// Shares one dual 18x18 signed multiply-add unit (37-bit dout, MAC_LAT cycles
// from operands to result) between two dot-product requesters. Jobs are
// granted round-robin and the grant is held for the whole job. The owner's
// beats stream onto mul_*, and a tag pipe of MAC_LAT stages marks which
// results are real. Tagged results are accumulated, and one result is
// returned per job.
// Optional build macro: NPU_DOT_SAT_EN selects a saturating accumulator.
// Without it, the accumulator wraps modulo 2^ACC_W.
module npu_dot_sched #(
  parameter int MAC_LAT = 2,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_last,
  input  logic [71:0]      req_op0,
  input  logic [71:0]      req_op1,
  output logic             mul_ce,
  output logic [17:0]      mul_a0,
  output logic [17:0]      mul_b0,
  output logic [17:0]      mul_a1,
  output logic [17:0]      mul_b1,
  input  logic [36:0]      mul_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_beats
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic [1:0]         req_ready_q, req_ready_d;
  logic               mul_ce_q, mul_ce_d;
  logic [71:0]        ops_q, ops_d;
  logic               t0v_q, t0v_d;
  logic               t0l_q, t0l_d;
  logic [MAC_LAT-1:0] pv_q, pv_d;
  logic [MAC_LAT-1:0] pl_q, pl_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;

  logic [71:0]        sel_op_s;
  logic               sel_last_s;
  logic               accept_s;
  logic               emerge_v_s;
  logic               emerge_l_s;
  logic [1:0]         gnt_oh_s;
  logic [ACC_W-1:0]   dout_ext_s;

  // Accumulate one term: either wrap, or clamp on signed overflow.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = a + b;
`ifdef NPU_DOT_SAT_EN
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      s = s;
    end
`endif
    return s;
  endfunction

  assign sel_op_s   = gnt_q ? req_op1 : req_op0;
  assign sel_last_s = req_last[gnt_q];
  assign gnt_oh_s   = gnt_q ? 2'b10 : 2'b01;
  assign accept_s   = (state_q == S_STREAM) & req_valid[gnt_q] & req_ready_q[gnt_q];
  assign emerge_v_s = mul_ce_q & pv_q[MAC_LAT-1];
  assign emerge_l_s = pl_q[MAC_LAT-1];
  assign dout_ext_s = {{(ACC_W-37){mul_dout[36]}}, mul_dout};

  // Next-state, operand staging, tag pipe advance and accumulation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    req_ready_d = 2'b00;
    mul_ce_d    = 1'b0;
    ops_d       = 72'd0;
    t0v_d       = 1'b0;
    t0l_d       = 1'b0;
    pv_d        = pv_q;
    pl_d        = pl_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;

    // Tag pipe moves in lockstep with the multiplier's own pipeline.
    if (mul_ce_q) begin
      pv_d[0] = t0v_q;
      pl_d[0] = t0l_q;
      for (int i = 1; i < MAC_LAT; i++) begin
        pv_d[i] = pv_q[i-1];
        pl_d[i] = pl_q[i-1];
      end
    end else begin
      pv_d = pv_q;
    end

    if (emerge_v_s) begin
      acc_d = acc_add(acc_q, dout_ext_s);
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          gnt_d       = (req_valid == 2'b11) ? ~last_gnt_q : req_valid[1];
          req_ready_d = gnt_d ? 2'b10 : 2'b01;
          mul_ce_d    = 1'b1;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        mul_ce_d = 1'b1;
        if (accept_s) begin
          ops_d = sel_op_s;
          t0v_d = 1'b1;
          t0l_d = sel_last_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (sel_last_s) begin
            state_d     = S_DRAIN;
            req_ready_d = 2'b00;
          end else begin
            req_ready_d = gnt_oh_s;
          end
        end else begin
          req_ready_d = gnt_oh_s;
        end
      end
      S_DRAIN: begin
        mul_ce_d = 1'b1;
        if (emerge_v_s && emerge_l_s) begin
          mul_ce_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          last_gnt_d  = gnt_q;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      req_ready_q <= 2'b00;
      mul_ce_q    <= 1'b0;
      ops_q       <= 72'd0;
      t0v_q       <= 1'b0;
      t0l_q       <= 1'b0;
      pv_q        <= {MAC_LAT{1'b0}};
      pl_q        <= {MAC_LAT{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      req_ready_q <= req_ready_d;
      mul_ce_q    <= mul_ce_d;
      ops_q       <= ops_d;
      t0v_q       <= t0v_d;
      t0l_q       <= t0l_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mul_ce    = mul_ce_q;
  assign mul_a0    = ops_q[71:54];
  assign mul_b0    = ops_q[53:36];
  assign mul_a1    = ops_q[35:18];
  assign mul_b1    = ops_q[17:0];
  assign res_valid = res_valid_q;
  assign res_id    = gnt_q;
  assign res_data  = acc_q;
  assign res_beats = cnt_q;

endmodule

// File: tb/tb_npu_dot_sched.sv
// Bench for npu_dot_sched: table-driven single-requester jobs, hand-written
// corner sequences, and randomized two-requester traffic checked against a
// job-level arithmetic model.
module tb_npu_dot_sched;
  localparam int LAT = 2;
  localparam int AW  = 40;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset;
  logic v0, v1, l0, l1;
  logic [71:0] op0, op1;
  logic [1:0] req_valid, req_last, req_ready;
  logic mul_ce;
  logic [17:0] mul_a0, mul_b0, mul_a1, mul_b1;
  logic [36:0] mul_dout;
  logic res_valid, res_ready, res_id;
  logic [AW-1:0] res_data;
  logic [CW-1:0] res_beats;

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;
  bit m_last;

  typedef struct { logic [AW-1:0] d; logic [CW-1:0] b; } exp_t;
  typedef struct { int n; logic [15:0][71:0] op; } job_t;
  typedef struct { int id; int n; int gap_at; logic [3:0][71:0] op; logic [AW-1:0] d; logic [CW-1:0] b; } vec_t;

  job_t jobs0[$];
  job_t jobs1[$];
  exp_t expq0[$];
  exp_t expq1[$];
  vec_t tbl[7];

`ifdef NPU_DOT_SAT_EN
  localparam logic [AW-1:0] SAT_EXP = 40'h7F_FFFF_FFFF;
`else
  localparam logic [AW-1:0] SAT_EXP = 40'h80_0000_0000;
`endif

  npu_dot_sched #(.MAC_LAT(LAT), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_op0(op0), .req_op1(op1),
    .mul_ce(mul_ce), .mul_a0(mul_a0), .mul_b0(mul_b0), .mul_a1(mul_a1), .mul_b1(mul_b1),
    .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_beats(res_beats)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint beat_val(input logic [71:0] op);
    logic signed [17:0] a0, b0, a1, b1;
    a0 = op[71:54]; b0 = op[53:36]; a1 = op[35:18]; b1 = op[17:0];
    return longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1);
  endfunction

  // External multiply-add unit: LAT-stage pipeline advancing on ce.
  logic [36:0] mstage [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mstage[0] <= 37'(beat_val({mul_a0, mul_b0, mul_a1, mul_b1}));
      for (int i = 1; i < LAT; i++) mstage[i] <= mstage[i-1];
    end
  end
  assign mul_dout = mstage[LAT-1];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm);
    total_cnt++;
    bad_cnt++;
    $display("FAIL %s: bound expired", nm);
  endfunction

  function automatic logic [71:0] pk(int a0, int b0, int a1, int b1);
    logic [17:0] x0, x1, x2, x3;
    x0 = 18'(a0); x1 = 18'(b0); x2 = 18'(a1); x3 = 18'(b1);
    return {x0, x1, x2, x3};
  endfunction

  // Job-level reference: sum of beat dot products, wrapped or clamped.
  function automatic logic [AW-1:0] job_model(input job_t j);
    longint s, mx, mn;
    s = 0;
    mx = (longint'(1) << (AW-1)) - 1;
    mn = -(longint'(1) << (AW-1));
    for (int b = 0; b < j.n; b++) begin
      s += beat_val(j.op[b]);
`ifdef NPU_DOT_SAT_EN
      if (s > mx) s = mx;
      if (s < mn) s = mn;
`endif
    end
    return AW'(s);
  endfunction

  function automatic logic [17:0] rnd18();
    case ($urandom_range(0, 3))
      0: return 18'h20000;
      1: return 18'h1FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  function automatic job_t gen_job(int maxn);
    job_t j;
    j.n = $urandom_range(1, maxn);
    for (int b = 0; b < 16; b++) j.op[b] = {rnd18(), rnd18(), rnd18(), rnd18()};
    return j;
  endfunction

  function automatic job_t mk1(logic [71:0] op);
    job_t j;
    j.n = 1;
    j.op = '0;
    j.op[0] = op;
    return j;
  endfunction

  function automatic void add_job(int r, job_t j);
    exp_t e;
    e.d = job_model(j);
    e.b = CW'(j.n);
    if (r == 0) begin jobs0.push_back(j); expq0.push_back(e); end
    else begin jobs1.push_back(j); expq1.push_back(e); end
  endfunction

  function automatic vec_t mkv(int id, int n, int gap, logic [71:0] o0, logic [71:0] o1,
                               logic [71:0] o2, logic [AW-1:0] d, logic [CW-1:0] b);
    vec_t v;
    v.id = id; v.n = n; v.gap_at = gap;
    v.op[0] = o0; v.op[1] = o1; v.op[2] = o2; v.op[3] = 72'd0;
    v.d = d; v.b = b;
    return v;
  endfunction

  task automatic set_req(int r, logic v, logic [71:0] op, logic l);
    if (r == 0) begin v0 = v; op0 = op; l0 = l; end
    else begin v1 = v; op1 = op; l1 = l; end
  endtask

  // Present one beat at a negedge and return at the negedge after it is taken.
  task automatic drive_beat(int r, logic [71:0] op, logic l, output bit ok, output int c0);
    ok = 1'b0;
    c0 = 0;
    set_req(r, 1'b1, op, l);
    for (int k = 0; k < 2000; k++) begin
      if (req_ready[r]) begin ok = 1'b1; c0 = cyc; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    else fail_now("beat_accept");
    set_req(r, 1'b0, 72'd0, 1'b0);
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (res_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("result_wait");
  endtask

  task automatic run_job(input vec_t v, string nm);
    bit ok;
    int c0;
    res_ready = 1'b1;
    for (int b = 0; b < v.n; b++) begin
      drive_beat(v.id, v.op[b], (b == v.n - 1), ok, c0);
      if (b == v.gap_at) @(negedge clk);
    end
    wait_res(ok);
    if (ok) begin
      chk({nm, "_data"}, res_data, v.d);
      chk({nm, "_id"}, res_id, v.id[0]);
      chk({nm, "_beats"}, res_beats, v.b);
      if (v.n == 1) chk({nm, "_latency"}, cyc - c0, LAT + 2);
      m_last = v.id[0];
      @(negedge clk);
      chk({nm, "_valid_drop"}, res_valid, 1'b0);
    end
  endtask

  task automatic drive_jobs(int r, int maxgap);
    bit ok;
    int c0, nj;
    job_t j;
    nj = (r == 0) ? jobs0.size() : jobs1.size();
    for (int i = 0; i < nj; i++) begin
      j = (r == 0) ? jobs0[i] : jobs1[i];
      for (int b = 0; b < j.n; b++) begin
        drive_beat(r, j.op[b], (b == j.n - 1), ok, c0);
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
    end
  endtask

  // Consume results, matching each against the owner's expected-result queue.
  task automatic collect(int n, bit rnd, bit alt, int bound);
    int got;
    exp_t e;
    bit have;
    got = 0;
    for (int k = 0; k < bound && got < n; k++) begin
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid && res_ready) begin
        if (alt) chk("rr_order", res_id, !m_last);
        have = 1'b0;
        if (res_id == 1'b0 && expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
        else if (res_id == 1'b1 && expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
        if (have) begin
          chk("stream_data", res_data, e.d);
          chk("stream_beats", res_beats, e.b);
        end else begin
          chk("extra_result", res_valid, 1'b0);
        end
        m_last = res_id;
        got++;
      end
      @(negedge clk);
    end
    if (got < n) fail_now("collect");
    res_ready = 1'b1;
  endtask

  initial begin
    bit ok, seen;
    int c0;
    job_t j;

    tbl[0] = mkv(0, 1, -1, pk(1, 2, 0, 0), 72'd0, 72'd0, 40'd2, 4'd1);
    tbl[1] = mkv(1, 2, 0, pk(3, 4, 5, 6), pk(-2, 7, 1, 1), 72'd0, 40'd29, 4'd2);
    tbl[2] = mkv(0, 1, -1, pk(-1, 1, 0, 0), 72'd0, 72'd0, 40'hFF_FFFF_FFFF, 4'd1);
    tbl[3] = mkv(1, 1, -1, pk(100, -3, 7, 7), 72'd0, 72'd0, 40'hFF_FFFF_FF05, 4'd1);
    tbl[4] = mkv(0, 3, 1, pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(1, 1, 1, 1), 40'd6, 4'd3);
    tbl[5] = mkv(1, 1, -1, pk(-131072, -131072, -131072, -131072), 72'd0, 72'd0,
                 40'h08_0000_0000, 4'd1);
    tbl[6] = mkv(0, 1, -1, pk(131071, -131072, 0, 0), 72'd0, 72'd0, 40'hFC_0002_0000, 4'd1);

    reset = 1'b0;
    res_ready = 1'b0;
    set_req(0, 1'b0, 72'd0, 1'b0);
    set_req(1, 1'b0, 72'd0, 1'b0);
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_mul_ce", mul_ce, 1'b0);
    chk("rst_mul_ops", {mul_a0, mul_b0, mul_a1} | {36'd0, mul_b1}, 54'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 40'd0);
    chk("rst_res_beats", res_beats, 4'd0);
    chk("rst_res_id", res_id, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Result backpressure with the other requester waiting.
    res_ready = 1'b0;
    drive_beat(1, pk(2, 3, 4, 5), 1'b1, ok, c0);
    wait_res(ok);
    set_req(0, 1'b1, pk(1, 1, 0, 0), 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_data", res_data, 40'd26);
      chk("bp_id", res_id, 1'b1);
      chk("bp_beats", res_beats, 4'd1);
      chk("bp_req_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    res_ready = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", res_valid, 1'b0);
    chk("bp_idle_ready", req_ready, 2'b00);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 2'b01);
    drive_beat(0, pk(1, 1, 0, 0), 1'b1, ok, c0);
    wait_res(ok);
    chk("bp_next_data", res_data, 40'd1);
    chk("bp_next_id", res_id, 1'b0);
    m_last = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness: both requesters always valid, grants must alternate.
    jobs0.delete(); jobs1.delete();
    add_job(0, mk1(pk(1, 2, 3, 4)));
    add_job(0, mk1(pk(2, 2, 2, 2)));
    add_job(1, mk1(pk(5, 5, 0, 0)));
    add_job(1, mk1(pk(-3, 3, 0, 0)));
    fork
      drive_jobs(0, 0);
      drive_jobs(1, 0);
      collect(4, 1'b0, 1'b1, 400);
    join
    repeat (2) @(negedge clk);

    // Reset in the middle of a 4-beat job.
    drive_beat(0, pk(1, 1, 0, 0), 1'b0, ok, c0);
    drive_beat(0, pk(1, 1, 0, 0), 1'b0, ok, c0);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_mul_ce", mul_ce, 1'b0);
    chk("mid_rst_mul_ops", {mul_a0, mul_b0, mul_a1} | {36'd0, mul_b1}, 54'd0);
    chk("mid_rst_res_data", res_data, 40'd0);
    chk("mid_rst_res_beats", res_beats, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    m_last = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      seen |= res_valid;
      @(negedge clk);
    end
    chk("mid_rst_no_result", seen, 1'b0);
    run_job(mkv(0, 1, -1, pk(5, 5, 0, 0), 72'd0, 72'd0, 40'd25, 4'd1), "post_rst");
    @(negedge clk);

    // Sixteen beats of 2^35 each: overflow and beat-counter wrap.
    j.n = 16;
    for (int b = 0; b < 16; b++) j.op[b] = pk(-131072, -131072, -131072, -131072);
    for (int b = 0; b < 16; b++) drive_beat(0, j.op[b], (b == 15), ok, c0);
    wait_res(ok);
    chk("sat_data_model", res_data, job_model(j));
    chk("sat_data", res_data, SAT_EXP);
    chk("sat_beats_wrap", res_beats, 4'd0);
    m_last = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic from both requesters with random backpressure.
    jobs0.delete(); jobs1.delete();
    for (int i = 0; i < 8; i++) begin
      add_job(0, gen_job(6));
      add_job(1, gen_job(6));
    end
    fork
      drive_jobs(0, 2);
      drive_jobs(1, 2);
      collect(16, 1'b1, 1'b0, 6000);
    join
    chk("rand_all_consumed", expq0.size() + expq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/npu_dot_sched.md
Name: npu_dot_sched

Overview:
- Shares one Gowin_MULTADDALU (dual 18x18 signed multiply-add, 37-bit dout) between two dot-product requesters.
- Round-robin arbitration per job; grant held for the whole job.
- Streams the granted requester's operand beats into the MULTADDALU and drives its ce.
- Accumulates dout across beats and returns one result per job with requester ID and beat count.

Parameters:
- MAC_LAT, 2, cycles from operands presented on mul_* to matching mul_dout valid (1..4).
- ACC_W, 48, accumulator/result width (40..64); dout sign-extended to ACC_W.
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester beat valid.
- req_ready  out  2  per-requester beat accept; at most one bit high.
- req_last  in  2  final beat of the job.
- req_op0  in  72  requester 0 beat {a0,b0,a1,b1}, 18 bits each, signed, a0 in MSBs.
- req_op1  in  72  requester 1 beat, same layout.
- mul_ce  out  1  MULTADDALU ce.
- mul_a0, mul_b0, mul_a1, mul_b1  out  18 each  registered MULTADDALU operands.
- mul_dout  in  37  MULTADDALU result, signed, a0*b0+a1*b1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_id  out  1  requester that owned the job.
- res_data  out  ACC_W  signed dot-product sum.
- res_beats  out  CNT_W  beats in the job, modulo 2^CNT_W.

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0; accumulator, counter and tag pipe cleared; RR pointer set so requester 0 wins the first tie. Reset mid-job aborts the job with no result.
- States: IDLE -> STREAM -> DRAIN -> RESULT -> IDLE.
- IDLE:
  - req_ready=0, mul_ce=0.
  - Any req_valid grants: one bit -> that requester; both -> the one not granted last. Grant registered -> STREAM next cycle.
  - Accumulator and beat counter cleared on grant.
- STREAM:
  - mul_ce=1.
  - req_ready[g]=1; the other bit is 0.
  - Beat accepted when req_valid[g]&req_ready[g]: its four operands are registered onto mul_* at that edge, with tag valid=1, last=req_last[g]. Beat counter +1.
  - No accepted beat: mul_* registered to 0, tag valid=0 (bubble).
  - Accepting the last beat -> DRAIN; req_ready drops the next cycle.
- Tag pipe: MAC_LAT-deep shift register, advancing every cycle mul_ce=1. When an emerging tag is valid, the accumulator adds sext(mul_dout).
- DRAIN:
  - mul_ce=1, req_ready=0, mul_* driven 0.
  - When the tag with last=1 emerges and is accumulated -> RESULT. res_valid asserts the cycle after the final accumulate, with res_data, res_id and res_beats.
- RESULT:
  - mul_ce=0.
  - res_* held stable while res_valid & !res_ready.
  - On res_valid & res_ready: res_valid drops next cycle, RR pointer updates, -> IDLE.
  - Earliest next grant is the cycle after IDLE is entered.
- Latency: single-beat job accepted at cycle t -> res_valid at cycle t+MAC_LAT+2.
- Arithmetic:
  - Accumulator wraps modulo 2^ACC_W (two's complement).
  - Zero-operand bubbles never contribute; only valid tags accumulate.
- Boundaries:
  - req_last on the first beat is a legal 1-beat job.
  - req_valid on the non-granted requester is ignored until IDLE.
  - res_ready high in the same cycle res_valid rises completes the handshake in that cycle.
  - Beat counter wraps silently.

Optional Feature:
- Macro NPU_DOT_SAT_EN.
- Defined: accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once saturated, the value stays clamped while further adds keep the same sign. An overflow check is added on each accumulate.
- Undefined: plain modulo-2^ACC_W wrap, no extra logic.

Test Plan:
- Single beat: requester 0, a0=1, b0=2, a1=b1=0, last=1 -> res_data=2, res_id=0, res_beats=1, res_valid at t+MAC_LAT+2.
- Multi-beat with bubble: r1 beats (3,4,5,6), idle cycle, (-2,7,1,1) last -> res_data=29, res_id=1, res_beats=2; the bubble adds nothing.
- Fairness: both req_valid held high continuously -> grants alternate 0,1,0,1 across four jobs; no requester is granted twice in a row.
- Result backpressure: res_ready low for 5 cycles after res_valid -> res_* stable, req_ready=0 throughout, next grant only after the handshake.
- Reset mid-STREAM: reset low after 2 of 4 beats -> all outputs 0 immediately, no res_valid; a fresh 1-beat job (5*5) then returns 25.
- Saturation (ACC_W=40): 16 beats of all operands = -131072, each beat adding 2^35:
  - NPU_DOT_SAT_EN defined -> res_data = 0x7F_FFFF_FFFF.
  - Undefined -> res_data = -2^39 (wrap).
